// File: rtl/collision_arbiter.sv
// collision_arbiter: frame-latched round-robin sharing of the ball collision input with per-source cooldown.
// Define COLLISION_ARB_MERGE_EN to OR all eligible edge codes into one pulse and cool every eligible source.
module collision_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int COOLDOWN_FRAMES = 3
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic [NUM_SRC-1:0]         req,
  input  logic [4*NUM_SRC-1:0]       edge_in,
  output logic                       collision,
  output logic [3:0]                 HitEdgeCode,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic [7:0]                 drop_cnt
);
  localparam int GW = $clog2(NUM_SRC);
  localparam int CW = COOLDOWN_FRAMES > 0 ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CW-1:0] CLOAD = CW'(COOLDOWN_FRAMES);
  typedef enum logic [1:0] {COLLECT, ARB, ISSUE} state_t;
  state_t state;
  logic [NUM_SRC-1:0] acc, snap, elig;
  logic [NUM_SRC-1:0][3:0] acc_edge, snap_edge;
  logic [NUM_SRC-1:0][CW-1:0] cool;
  logic [GW-1:0] last_grant, win, idx;
`ifdef COLLISION_ARB_MERGE_EN
  logic [3:0] merged;
`else
  logic [3:0] pop;
  logic [8:0] dsum;
  logic [7:0] drop_next;
`endif
  always_comb begin
    win = last_grant;
    idx = '0;
    for (int i = 0; i < NUM_SRC; i++) elig[i] = snap[i] && cool[i] == '0;
    // Walk downward so the nearest set bit after last_grant is assigned last.
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % NUM_SRC);
      if (elig[idx]) win = idx;
    end
`ifdef COLLISION_ARB_MERGE_EN
    merged = '0;
    for (int i = 0; i < NUM_SRC; i++) merged = elig[i] ? merged | snap_edge[i] : merged;
`else
    pop = '0;
    for (int i = 0; i < NUM_SRC; i++) pop = pop + 4'(elig[i]);
    dsum = {1'b0, drop_cnt} + 9'(pop) - 9'd1;
    drop_next = dsum > 9'd255 ? 8'hFF : dsum[7:0];
`endif
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= COLLECT;
      collision <= 1'b0;
      HitEdgeCode <= '0;
      grant_id <= '0;
      drop_cnt <= '0;
      acc <= '0;
      acc_edge <= '0;
      snap <= '0;
      snap_edge <= '0;
      cool <= '0;
      last_grant <= GW'(NUM_SRC - 1);
    end else begin
      collision <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++)
        if (req[i]) begin
          acc[i] <= 1'b1;
          acc_edge[i] <= acc_edge[i] | edge_in[4*i+:4];
        end
      case (state)
        COLLECT: if (startOfFrame) begin
          snap <= acc | req;
          for (int i = 0; i < NUM_SRC; i++) begin
            snap_edge[i] <= acc_edge[i] | (edge_in[4*i+:4] & {4{req[i]}});
            if (cool[i] != '0) cool[i] <= cool[i] - CW'(1);
          end
          acc <= '0;
          acc_edge <= '0;
          state <= ARB;
        end
        ARB: begin
          state <= elig == '0 ? COLLECT : ISSUE;
          if (elig != '0) begin
            collision <= 1'b1;
            grant_id <= win;
            last_grant <= win;
`ifdef COLLISION_ARB_MERGE_EN
            HitEdgeCode <= merged;
            for (int i = 0; i < NUM_SRC; i++) if (elig[i]) cool[i] <= CLOAD;
`else
            HitEdgeCode <= snap_edge[win];
            cool[win] <= CLOAD;
            drop_cnt <= drop_next;
`endif
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule
